// File: rtl/ex_lsu.sv
// ex_lsu: in-order load/store unit sitting between the issue stage and a data cache.
// Loads are tracked in a DEPTH-entry circular FIFO until the cache signals completion.
// A completed load produces a one-cycle register-file writeback on the following cycle.
// Optional feature: define LS_MISALIGN_CHECK_EN to trap misaligned halfword/word accesses
// instead of forwarding them to the cache.
module ex_lsu #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned QUEEN_SIZE = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,

    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [3:0]               issue_op,
    input  logic [31:0]              issue_base,
    input  logic [31:0]              issue_offset,
    input  logic [31:0]              issue_sdata,
    input  logic [4:0]               issue_target,

    output logic                     wb_en,
    output logic [4:0]               wb_target,
    output logic [31:0]              wb_data,

    output logic                     en_ls,
    output logic                     ls_oper,
    output logic [31:0]              ls_addr,
    output logic [7:0]               ls_size,
    output logic [31:0]              ls_data,

    input  logic [31:0]              qsize,
    input  logic                     finish,
    input  logic [31:0]              ls_data_in,

    output logic [$clog2(DEPTH):0]   pending,

    output logic                     misalign,
    output logic [31:0]              misalign_addr
);

    localparam int unsigned     PtrW     = $clog2(DEPTH);
    localparam int unsigned     CntW     = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
    localparam logic [31:0]     QueueLim = 32'(QUEEN_SIZE);

    typedef enum logic {
        StFree,
        StWait
    } entry_st_e;

    typedef struct packed {
        logic [4:0] target;
        logic [2:0] funct3;
    } ld_entry_t;

    // Pending-load bookkeeping
    ld_entry_t       fifo_q [DEPTH];
    entry_st_e       ent_q  [DEPTH];
    logic [PtrW-1:0] wptr_q;
    logic [PtrW-1:0] rptr_q;
    logic [CntW-1:0] pending_q;
    logic [CntW-1:0] pending_d;

    // Registered outputs
    logic            en_ls_q;
    logic            ls_oper_q;
    logic [31:0]     ls_addr_q;
    logic [7:0]      ls_size_q;
    logic [31:0]     ls_data_q;
    logic            wb_en_q;
    logic [4:0]      wb_target_q;
    logic [31:0]     wb_data_q;

    // Combinational issue/complete decode
    logic            is_store;
    logic [31:0]     eff_addr;
    logic            slot_ok;
    logic            accept;
    logic            mis_hit;
    logic            req_fire;
    logic            push;
    logic            pop;
    ld_entry_t       head;
    logic [7:0]      req_size;
    logic [31:0]     ld_value;

    // Little-endian extraction of the loaded value; data arrives aligned to the access address.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{d[7]}}, d[7:0]};
            3'b001:  r = {{16{d[15]}}, d[15:0]};
            3'b100:  r = {24'b0, d[7:0]};
            3'b101:  r = {16'b0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Issue handshake; a same-cycle completion deliberately does not free a slot.
    always_comb begin
        is_store    = issue_op[3];
        eff_addr    = issue_base + issue_offset;
        slot_ok     = is_store | (pending_q < DepthCnt);
        issue_ready = rdy & ~rst & (qsize < QueueLim) & slot_ok;
        accept      = issue_valid & issue_ready;
        req_fire    = accept & ~mis_hit;
        push        = req_fire & ~is_store;
        head        = fifo_q[rptr_q];
        pop         = finish & (pending_q != '0) & (ent_q[rptr_q] == StWait);
        ld_value    = load_extract(head.funct3, ls_data_in);
    end

    // Access size in bytes from funct3 width bits
    always_comb begin
        req_size = 8'd4;
        case (issue_op[1:0])
            2'b00:   req_size = 8'd1;
            2'b01:   req_size = 8'd2;
            default: req_size = 8'd4;
        endcase
    end

    // Occupancy: push and pop in the same cycle cancel out
    always_comb begin
        pending_d = pending_q;
        case ({push, pop})
            2'b10:   pending_d = pending_q + CntW'(1);
            2'b01:   pending_d = pending_q - CntW'(1);
            default: pending_d = pending_q;
        endcase
    end

`ifdef LS_MISALIGN_CHECK_EN
    logic        misaligned;
    logic        misalign_q;
    logic [31:0] misalign_addr_q;

    // Halfword must be 2-byte aligned, word 4-byte aligned
    always_comb begin
        misaligned = 1'b0;
        case (issue_op[1:0])
            2'b01:   misaligned = eff_addr[0];
            2'b10:   misaligned = (eff_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign mis_hit = accept & misaligned;

    // Misalign trap pulse; address is held until the next trap
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else if (rdy) begin
            misalign_q <= mis_hit;
            if (mis_hit) begin
                misalign_addr_q <= eff_addr;
            end
        end
    end

    assign misalign      = misalign_q;
    assign misalign_addr = misalign_addr_q;
`else
    assign mis_hit       = 1'b0;
    assign misalign      = 1'b0;
    assign misalign_addr = '0;
`endif

    // Cache request, writeback, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            en_ls_q     <= 1'b0;
            ls_oper_q   <= 1'b0;
            ls_addr_q   <= '0;
            ls_size_q   <= '0;
            ls_data_q   <= '0;
            wb_en_q     <= 1'b0;
            wb_target_q <= '0;
            wb_data_q   <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            pending_q   <= '0;
        end else if (rdy) begin
            en_ls_q <= req_fire;
            if (req_fire) begin
                ls_oper_q <= is_store;
                ls_addr_q <= eff_addr;
                ls_size_q <= req_size;
                ls_data_q <= is_store ? issue_sdata : 32'h0;
            end
            // x0 loads still occupy a slot but never write back
            wb_en_q <= pop & (head.target != 5'd0);
            if (pop) begin
                wb_target_q <= head.target;
                wb_data_q   <= ld_value;
                rptr_q      <= rptr_q + PtrW'(1);
            end
            if (push) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            pending_q <= pending_d;
        end
    end

    // FIFO payload; contents are only meaningful while the entry is in StWait
    always_ff @(posedge clk) begin
        if (!rst && rdy && push) begin
            fifo_q[wptr_q] <= '{target: issue_target, funct3: issue_op[2:0]};
        end
    end

    // Per-entry state: FREE on reset/pop, WAIT on push
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= StFree;
            end
        end else if (rdy) begin
            if (pop) begin
                ent_q[rptr_q] <= StFree;
            end
            if (push) begin
                ent_q[wptr_q] <= StWait;
            end
        end
    end

    assign en_ls     = en_ls_q;
    assign ls_oper   = ls_oper_q;
    assign ls_addr   = ls_addr_q;
    assign ls_size   = ls_size_q;
    assign ls_data   = ls_data_q;
    assign wb_en     = wb_en_q;
    assign wb_target = wb_target_q;
    assign wb_data   = wb_data_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_ex_lsu.sv
// tb_ex_lsu: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_ex_lsu;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned QS    = 16;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        issue_valid, issue_ready;
    logic [3:0]  issue_op;
    logic [31:0] issue_base, issue_offset, issue_sdata;
    logic [4:0]  issue_target;
    logic        wb_en;
    logic [4:0]  wb_target;
    logic [31:0] wb_data;
    logic        en_ls, ls_oper;
    logic [31:0] ls_addr;
    logic [7:0]  ls_size;
    logic [31:0] ls_data;
    logic [31:0] qsize;
    logic        finish;
    logic [31:0] ls_data_in;
    logic [2:0]  pending;
    logic        misalign;
    logic [31:0] misalign_addr;

    always #5 clk = ~clk;

    ex_lsu #(.DEPTH(DEPTH), .QUEEN_SIZE(QS)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_base(issue_base), .issue_offset(issue_offset), .issue_sdata(issue_sdata),
        .issue_target(issue_target),
        .wb_en(wb_en), .wb_target(wb_target), .wb_data(wb_data),
        .en_ls(en_ls), .ls_oper(ls_oper), .ls_addr(ls_addr), .ls_size(ls_size),
        .ls_data(ls_data), .qsize(qsize), .finish(finish), .ls_data_in(ls_data_in),
        .pending(pending), .misalign(misalign), .misalign_addr(misalign_addr)
    );

    typedef struct packed {
        logic [4:0] tgt;
        logic [2:0] f3;
    } ld_t;

    ld_t         loads[$];
    int          tests = 0;
    int          errors = 0;

    logic        e_en = 0, e_oper = 0, e_wb = 0, e_mis = 0;
    logic [31:0] e_addr = 0, e_data = 0, e_wbd = 0, e_misa = 0;
    logic [7:0]  e_size = 0;
    logic [4:0]  e_wbt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference value of a completed load, computed arithmetically
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] d);
        int    nbytes;
        longint full, v;
        nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        full   = longint'(1) << (8 * nbytes);
        v      = longint'(d) % full;
        if (!f3[2] && nbytes < 4 && v >= full / 2) v = v - full;
        return 32'(v);
    endfunction

    task automatic set_idle();
        rst = 0; rdy = 1; issue_valid = 0; issue_op = 0; issue_base = 0; issue_offset = 0;
        issue_sdata = 0; issue_target = 0; qsize = 0; finish = 0; ls_data_in = 0;
    endtask

    // Apply the currently driven inputs for one clock and check everything against the model
    task automatic cycle();
        logic        exp_ready, acc, mis;
        logic [31:0] ea;
        ld_t         h;
        #1;
        exp_ready = rdy && !rst && (qsize < QS) && (issue_op[3] || loads.size() < DEPTH);
        check("issue_ready", {31'b0, issue_ready}, {31'b0, exp_ready});
        if (rst) begin
            loads.delete();
            e_en = 0; e_oper = 0; e_addr = 0; e_size = 0; e_data = 0;
            e_wb = 0; e_wbt = 0; e_wbd = 0; e_mis = 0; e_misa = 0;
        end else if (rdy) begin
            acc = issue_valid && exp_ready;
            ea  = issue_base + issue_offset;
            mis = 0;
`ifdef LS_MISALIGN_CHECK_EN
            mis = acc && ((issue_op[1:0] == 2'd1 && ea % 2 != 0) ||
                          (issue_op[1:0] == 2'd2 && ea % 4 != 0));
`endif
            e_en = acc && !mis;
            if (e_en) begin
                e_oper = issue_op[3];
                e_addr = ea;
                e_size = 8'(1 << issue_op[1:0]);
                e_data = issue_op[3] ? issue_sdata : 32'h0;
            end
            e_mis = mis;
            if (mis) e_misa = ea;
            e_wb = 0;
            if (finish && loads.size() > 0) begin
                h     = loads.pop_front();
                e_wb  = (h.tgt != 0);
                e_wbt = h.tgt;
                e_wbd = ref_load(h.f3, ls_data_in);
            end
            if (e_en && !issue_op[3]) loads.push_back('{tgt: issue_target, f3: issue_op[2:0]});
        end
        @(posedge clk);
        @(negedge clk);
        check("en_ls", {31'b0, en_ls}, {31'b0, e_en});
        if (e_en) begin
            check("ls_oper", {31'b0, ls_oper}, {31'b0, e_oper});
            check("ls_addr", ls_addr, e_addr);
            check("ls_size", {24'b0, ls_size}, {24'b0, e_size});
            check("ls_data", ls_data, e_data);
        end
        check("wb_en", {31'b0, wb_en}, {31'b0, e_wb});
        if (e_wb) begin
            check("wb_target", {27'b0, wb_target}, {27'b0, e_wbt});
            check("wb_data", wb_data, e_wbd);
        end
        check("pending", {29'b0, pending}, 32'(loads.size()));
        check("misalign", {31'b0, misalign}, {31'b0, e_mis});
        if (e_mis) check("misalign_addr", misalign_addr, e_misa);
    endtask

    task automatic load(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] tgt);
        set_idle();
        issue_valid = 1; issue_op = op; issue_base = addr; issue_target = tgt;
        cycle();
    endtask

    task automatic complete(input logic [31:0] din);
        set_idle();
        finish = 1; ls_data_in = din;
        cycle();
    endtask

    logic [3:0] ops[8];

    initial begin
        ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA};
        set_idle();
        rst = 1;
        @(negedge clk);

        // Reset state
        cycle();
        check("rst_en_ls", {31'b0, en_ls}, 32'h0);
        check("rst_ls_addr", ls_addr, 32'h0);
        check("rst_ls_size", {24'b0, ls_size}, 32'h0);
        check("rst_ls_data", ls_data, 32'h0);
        check("rst_ls_oper", {31'b0, ls_oper}, 32'h0);
        check("rst_wb_target", {27'b0, wb_target}, 32'h0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_pending", {29'b0, pending}, 32'h0);

        // SW with negative offset
        set_idle();
        issue_valid = 1; issue_op = 4'hA; issue_base = 32'h100; issue_offset = 32'hFFFF_FFFC;
        issue_sdata = 32'hDEAD_BEEF;
        cycle();
        check("sw_en_ls", {31'b0, en_ls}, 32'h1);
        check("sw_addr", ls_addr, 32'h0000_00FC);
        check("sw_size", {24'b0, ls_size}, 32'h4);
        check("sw_oper", {31'b0, ls_oper}, 32'h1);
        check("sw_data", ls_data, 32'hDEAD_BEEF);
        set_idle();
        cycle();
        check("sw_one_cycle", {31'b0, en_ls}, 32'h0);

        // Sign/zero extension
        load(4'h0, 32'h40, 5'd5);
        complete(32'h0000_00F0);
        check("lb_wb_data", wb_data, 32'hFFFF_FFF0);
        check("lb_wb_target", {27'b0, wb_target}, 32'h5);
        load(4'h4, 32'h40, 5'd5);
        complete(32'h0000_00F0);
        check("lbu_wb_data", wb_data, 32'h0000_00F0);
        load(4'h5, 32'h42, 5'd7);
        check("lhu_size", {24'b0, ls_size}, 32'h2);
        complete(32'h0000_ABCD);
        check("lhu_wb_data", wb_data, 32'h0000_ABCD);

        // Fill, stall loads, stores still flow, slot frees one cycle after finish
        for (int i = 0; i < DEPTH; i++) load(4'h2, 32'h200 + 32'(4 * i), 5'(i + 1));
        check("full_pending", {29'b0, pending}, DEPTH);
        load(4'h2, 32'h300, 5'd9);
        check("full_no_issue", {31'b0, en_ls}, 32'h0);
        set_idle();
        issue_valid = 1; issue_op = 4'h8; issue_base = 32'h500; issue_sdata = 32'h55;
        cycle();
        check("full_store", {31'b0, en_ls}, 32'h1);
        set_idle();
        finish = 1; ls_data_in = 32'h1111_1111;
        issue_valid = 1; issue_op = 4'h2; issue_base = 32'h304; issue_target = 5'd10;
        cycle();
        load(4'h2, 32'h308, 5'd11);
        complete(32'h2222_2222);
        complete(32'h3333_3333);
        // Push and pop together at pending=2, across pointer wrap
        set_idle();
        finish = 1; ls_data_in = 32'h4444_4444;
        issue_valid = 1; issue_op = 4'h1; issue_base = 32'h30C; issue_target = 5'd12;
        cycle();
        check("pushpop_pending", {29'b0, pending}, 32'h2);
        complete(32'h5555_5555);
        complete(32'h0000_8001);
        check("wrap_lh", wb_data, 32'hFFFF_8001);

        // Cache queue full
        set_idle();
        issue_valid = 1; issue_op = 4'hA; qsize = QS;
        cycle();
        check("qfull_en_ls", {31'b0, en_ls}, 32'h0);

        // Reset discards outstanding loads
        for (int i = 0; i < 3; i++) load(4'h2, 32'h600, 5'd3);
        set_idle();
        rst = 1; finish = 1;
        cycle();
        complete(32'hFFFF_FFFF);
        check("rst_drop_wb", {31'b0, wb_en}, 32'h0);
        check("rst_drop_pending", {29'b0, pending}, 32'h0);

        // Misaligned word
        set_idle();
        issue_valid = 1; issue_op = 4'h2; issue_base = 32'h100; issue_offset = 32'h2;
        issue_target = 5'd4;
        cycle();
`ifdef LS_MISALIGN_CHECK_EN
        check("mis_pulse", {31'b0, misalign}, 32'h1);
        check("mis_addr", misalign_addr, 32'h102);
        check("mis_no_req", {31'b0, en_ls}, 32'h0);
`else
        check("mis_addr_issued", ls_addr, 32'h102);
        check("mis_tied", {31'b0, misalign}, 32'h0);
`endif
        set_idle();
        rst = 1;
        cycle();

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            rst          = ($urandom_range(0, 63) == 0);
            rdy          = ($urandom_range(0, 9) != 0);
            issue_valid  = $urandom_range(0, 1);
            issue_op     = ops[$urandom_range(0, 7)];
            issue_base   = $urandom;
            issue_offset = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            issue_sdata  = $urandom;
            issue_target = 5'($urandom_range(0, 31));
            qsize        = ($urandom_range(0, 9) == 0) ? QS + $urandom_range(0, 3)
                                                       : $urandom_range(0, QS - 1);
            finish       = $urandom_range(0, 1);
            ls_data_in   = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
